// File: rtl/turbo_addr_seq_if.sv
// turbo_addr_seq_if
// Output stream from the turbo address sequencer to the extrinsic-memory
// controller. One permuted address per transfer, valid/ready handshake.
//   out_valid  payload below is valid
//   out_ready  consumer accepts the current payload
//   out_addr   permuted index (low field of the ROM word)
//   out_bank   sub-block tag (high field of the ROM word)
//   out_idx    natural-order position of this entry in the emitted frame
//   out_last   final entry of the frame
// master = sequencer side, slave = consumer side.
interface turbo_addr_seq_if #(
  parameter int A_WIDTH = 12,
  parameter int OFFSET  = 8
);
  logic               out_valid;
  logic               out_ready;
  logic [A_WIDTH-1:0] out_addr;
  logic [OFFSET-1:0]  out_bank;
  logic [A_WIDTH-1:0] out_idx;
  logic               out_last;

  modport master (
    output out_valid, out_addr, out_bank, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_addr, out_bank, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/turbo_addr_seq.sv
// turbo_addr_seq
// Scans the interleaver/deinterleaver address ROM in natural order, drops
// permuted indices that fall outside the current frame, and streams the
// surviving addresses to the extrinsic-memory controller.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a scan (only honoured when idle)
//   mode_in        1 = interleave table, 0 = deinterleave table
//   frame_len      number of addresses to emit (0..2**A_WIDTH)
//   raddr          ROM read address (registered)
//   mod_int_dint   ROM table select (latched mode)
//   rom_data       ROM word, combinational from raddr
//   out            output stream (turbo_addr_seq_if.master)
//   busy           scan in progress
//   done           one-cycle pulse on normal completion
//   err            one-cycle pulse if the ROM ran out before frame_len entries
module turbo_addr_seq #(
  parameter int A_WIDTH = 12,
  parameter int OFFSET  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode_in,
  input  logic [A_WIDTH:0]           frame_len,
  output logic [A_WIDTH-1:0]         raddr,
  output logic                       mod_int_dint,
  input  logic [A_WIDTH+OFFSET-1:0]  rom_data,
  turbo_addr_seq_if.master           out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [A_WIDTH-1:0] CNT_MAX = {A_WIDTH{1'b1}};
  localparam logic [A_WIDTH-1:0] CNT_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [A_WIDTH:0]   LEN_ONE = {{A_WIDTH{1'b0}}, 1'b1};

  logic [1:0]         state_reg;
  logic [A_WIDTH-1:0] cnt_reg;
  logic [A_WIDTH:0]   ecnt_reg;
  logic [A_WIDTH:0]   len_reg;
  logic               mode_reg;
  logic               err_flag_reg;
  logic               done_reg;
  logic               err_reg;

  logic               valid_reg;
  logic [A_WIDTH-1:0] addr_reg;
  logic [OFFSET-1:0]  bank_reg;
  logic [A_WIDTH-1:0] idx_reg;
  logic               last_reg;

  logic [A_WIDTH-1:0] rom_idx;
  logic [OFFSET-1:0]  rom_bank;
  logic               slot_free;
  logic               keep;
  logic               is_last;
  logic               scan_end;

  assign rom_idx   = rom_data[A_WIDTH-1:0];
  assign rom_bank  = rom_data[A_WIDTH+OFFSET-1:A_WIDTH];
  assign slot_free = !valid_reg || out.out_ready;
  // Extra MSB so a full-size frame (2**A_WIDTH) keeps every index.
  assign keep      = ({1'b0, rom_idx} < len_reg);
  assign is_last   = (ecnt_reg == (len_reg - LEN_ONE));
  assign scan_end  = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      ecnt_reg     <= '0;
      len_reg      <= '0;
      mode_reg     <= 1'b0;
      err_flag_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      addr_reg     <= '0;
      bank_reg     <= '0;
      idx_reg      <= '0;
      last_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (frame_len == '0) begin
              done_reg <= 1'b1;
            end else begin
              mode_reg     <= mode_in;
              len_reg      <= frame_len;
              cnt_reg      <= '0;
              ecnt_reg     <= '0;
              err_flag_reg <= 1'b0;
              state_reg    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (slot_free) begin
            if (keep) begin
              valid_reg <= 1'b1;
              addr_reg  <= rom_idx;
              bank_reg  <= rom_bank;
              idx_reg   <= ecnt_reg[A_WIDTH-1:0];
              last_reg  <= is_last;
              ecnt_reg  <= ecnt_reg + LEN_ONE;
            end else begin
              valid_reg <= 1'b0;
            end
            // Address freezes once the frame is complete and never wraps.
            if (!scan_end && !(keep && is_last)) begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
            if (keep && is_last) begin
              state_reg <= ST_DRAIN;
            end else if (scan_end) begin
              state_reg    <= ST_DRAIN;
              err_flag_reg <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Output empty or being taken this cycle: the scan is over.
          if (slot_free) begin
            valid_reg <= 1'b0;
            if (err_flag_reg) begin
              err_reg <= 1'b1;
            end else begin
              done_reg <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign raddr         = cnt_reg;
  assign mod_int_dint  = mode_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign err           = err_reg;
  assign out.out_valid = valid_reg;
  assign out.out_addr  = addr_reg;
  assign out.out_bank  = bank_reg;
  assign out.out_idx   = idx_reg;
  assign out.out_last  = last_reg;

endmodule
